// File: rtl/eq_audio_pkg.sv
// Shared sample types for the equalizer audio path.
package eq_audio_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock divider: generates BCLK, the falling-edge tick
// and the frame bit counter (next value exposed for same-clk use).
module i2s_clk_gen #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32,
  localparam int KW = $clog2(2*SLOT_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_bclk,
  output logic          o_fall,
  output logic [KW-1:0] o_bit_cnt
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [KW-1:0] k_q, k_d;
  logic          wrap;
  logic          fall;

  always_comb begin
    wrap   = (div_q == DW'(CLK_DIV-1));
    div_d  = wrap ? '0 : div_q + 1'b1;
    bclk_d = wrap ? ~bclk_q : bclk_q;
    fall   = wrap & bclk_q;
    k_d    = k_q;
    if (fall) begin
      k_d = (k_q == KW'(2*SLOT_BITS-1)) ? '0 : k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      k_q    <= KW'(2*SLOT_BITS-1);
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      k_q    <= k_d;
    end
  end

  assign o_bclk    = bclk_q;
  assign o_fall    = fall;
  assign o_bit_cnt = k_d;
endmodule

// File: rtl/eq_i2s_tx.sv
// Philips I2S master transmitter with a one-frame stereo buffer.
// Build option I2S_TX_UNDERRUN_MUTE_EN: underrun frames send silence.
module eq_i2s_tx
  import eq_audio_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cs,
  input  logic [SAMPLE_W-1:0] i_sample_l,
  input  logic [SAMPLE_W-1:0] i_sample_r,
  output logic                o_bclk,
  output logic                o_lrck,
  output logic                o_sdata,
  output logic                o_frame_req,
  output logic                o_overrun,
  output logic                o_underrun
);
  localparam int KW = $clog2(2*SLOT_BITS);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MuteEn = 1'b1;
`else
  localparam bit MuteEn = 1'b0;
`endif

  logic          fall;
  logic [KW-1:0] k;
  logic [KW-1:0] p;
  logic          load;
  sample_t       word;

  stereo_t buf_q, buf_d;
  stereo_t frame_q, frame_d;
  logic    full_q, full_d;
  logic    lrck_q, lrck_d;
  logic    sdata_q, sdata_d;
  logic    req_q, req_d;
  logic    ovr_q, ovr_d;
  logic    und_q, und_d;

  i2s_clk_gen #(
    .CLK_DIV  (CLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_bclk   (o_bclk),
    .o_fall   (fall),
    .o_bit_cnt(k)
  );

  always_comb begin
    load    = fall && (k == '0);
    buf_d   = buf_q;
    full_d  = full_q;
    frame_d = frame_q;
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    req_d   = load;
    und_d   = load & ~full_q;
    ovr_d   = i_cs & full_q & ~load;
    p       = '0;
    word    = '0;

    // The load consumes the pre-write buffer; a same-clk strobe refills it.
    if (load) begin
      if (full_q)      frame_d = buf_q;
      else if (MuteEn) frame_d = '0;
      full_d = 1'b0;
    end
    if (i_cs) begin
      buf_d.l = sample_t'(i_sample_l);
      buf_d.r = sample_t'(i_sample_r);
      full_d  = 1'b1;
    end

    if (fall) begin
      lrck_d = (k >= KW'(SLOT_BITS-1)) &&
               (k <= KW'(2*SLOT_BITS-2));
      if (k < KW'(SLOT_BITS)) begin
        word = frame_d.l;
        p    = k;
      end else begin
        word = frame_d.r;
        p    = k - KW'(SLOT_BITS);
      end
      sdata_d = (p < KW'(SAMPLE_W)) &&
                word[4'd15 - p[3:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      frame_q <= '0;
      full_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      req_q   <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      frame_q <= frame_d;
      full_q  <= full_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
      req_q   <= req_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
    end
  end

  assign o_lrck      = lrck_q;
  assign o_sdata     = sdata_q;
  assign o_frame_req = req_q;
  assign o_overrun   = ovr_q;
  assign o_underrun  = und_q;
endmodule

// File: tb/tb_eq_i2s_tx.sv
// Directed bench for eq_i2s_tx (CLK_DIV=2, SLOT_BITS=32, 256 clk/frame).
module tb_eq_i2s_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cs = 1'b0;
  logic [15:0] i_sample_l = '0;
  logic [15:0] i_sample_r = '0;
  logic        o_bclk, o_lrck, o_sdata;
  logic        o_frame_req, o_overrun, o_underrun;

  int vecs = 0;
  int errs = 0;
  int cyc;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  eq_i2s_tx #(.CLK_DIV(2), .SLOT_BITS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cs       (i_cs),
    .i_sample_l (i_sample_l),
    .i_sample_r (i_sample_r),
    .o_bclk     (o_bclk),
    .o_lrck     (o_lrck),
    .o_sdata    (o_sdata),
    .o_frame_req(o_frame_req),
    .o_overrun  (o_overrun),
    .o_underrun (o_underrun)
  );

  always #5 clk = ~clk;

  // clk edges since reset release; fall ticks land on multiples of 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [63:0] exp_sd(logic [15:0] l, logic [15:0] r);
    return {l, 16'h0, r, 16'h0};
  endfunction

  function automatic logic [5:0] outs();
    return {o_bclk, o_lrck, o_sdata, o_frame_req, o_overrun, o_underrun};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_load();
    for (int i = 0; i < 300; i++) begin
      step();
      if (cyc % 256 == 4) break;
    end
  endtask

  // starts at the load tick (k=0), ends at the k=63 tick
  task automatic capture(output logic [63:0] sd, output logic [63:0] lr);
    for (int k = 0; k < 64; k++) begin
      sd[63-k] = o_sdata;
      lr[63-k] = o_lrck;
      if (k < 63) repeat (4) step();
    end
  endtask

  task automatic strobe(logic [15:0] l, logic [15:0] r);
    @(negedge clk);
    i_cs = 1'b1;
    i_sample_l = l;
    i_sample_r = r;
  endtask

  task automatic test_reset();
    logic [63:0] sd, lr;
    vecs++;
    if (outs() !== 6'b0) begin
      errs++;
      $display("FAIL reset_outs got=%b want=000000", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vecs++;
    if (o_bclk !== 1'b0) begin
      errs++;
      $display("FAIL bclk_c1 got=%b want=0", o_bclk);
    end
    step();
    vecs++;
    if ({o_bclk, o_frame_req} !== 2'b10) begin
      errs++;
      $display("FAIL bclk_req_c2 got=%b want=10", {o_bclk, o_frame_req});
    end
    step();
    step();
    vecs++;
    if ({o_bclk, o_frame_req, o_underrun, o_sdata, o_lrck} !== 5'b01100) begin
      errs++;
      $display("FAIL first_tick got=%b want=01100",
               {o_bclk, o_frame_req, o_underrun, o_sdata, o_lrck});
    end
    capture(sd, lr);
    vecs++;
    if (sd !== 64'h0) begin
      errs++;
      $display("FAIL empty_frame got=%h want=0", sd);
    end
    vecs++;
    if (lr !== LR_EXP) begin
      errs++;
      $display("FAIL lrck_shape got=%h want=%h", lr, LR_EXP);
    end
  endtask

  task automatic test_pattern();
    logic [63:0] sd, lr;
    strobe(16'hA5C3, 16'h8001);
    step();
    i_cs = 1'b0;
    vecs++;
    if (o_overrun !== 1'b0) begin
      errs++;
      $display("FAIL pat_ovr got=%b want=0", o_overrun);
    end
    goto_load();
    vecs++;
    if ({o_frame_req, o_underrun, o_sdata} !== 3'b101) begin
      errs++;
      $display("FAIL pat_load got=%b want=101",
               {o_frame_req, o_underrun, o_sdata});
    end
    capture(sd, lr);
    vecs++;
    if (sd !== exp_sd(16'hA5C3, 16'h8001)) begin
      errs++;
      $display("FAIL pat_frame got=%h want=%h", sd,
               exp_sd(16'hA5C3, 16'h8001));
    end
    vecs++;
    if (lr !== LR_EXP) begin
      errs++;
      $display("FAIL pat_lrck got=%h want=%h", lr, LR_EXP);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] sd, lr;
    strobe(16'h1111, 16'h1111);
    step();
    vecs++;
    if (o_overrun !== 1'b0) begin
      errs++;
      $display("FAIL ovr_first got=%b want=0", o_overrun);
    end
    strobe(16'h2222, 16'h3333);
    step();
    i_cs = 1'b0;
    vecs++;
    if (o_overrun !== 1'b1) begin
      errs++;
      $display("FAIL ovr_second got=%b want=1", o_overrun);
    end
    step();
    vecs++;
    if (o_overrun !== 1'b0) begin
      errs++;
      $display("FAIL ovr_clear got=%b want=0", o_overrun);
    end
    goto_load();
    vecs++;
    if ({o_frame_req, o_underrun} !== 2'b10) begin
      errs++;
      $display("FAIL ovr_load got=%b want=10", {o_frame_req, o_underrun});
    end
    capture(sd, lr);
    vecs++;
    if (sd !== exp_sd(16'h2222, 16'h3333)) begin
      errs++;
      $display("FAIL ovr_frame got=%h want=%h", sd,
               exp_sd(16'h2222, 16'h3333));
    end
  endtask

  task automatic test_same_clk();
    logic [63:0] sd, lr, want;
    repeat (3) @(negedge clk);
    strobe(16'h7FFF, 16'h1234);
    step();
    i_cs = 1'b0;
    vecs++;
    if ({cyc % 256 == 4, o_frame_req, o_underrun, o_overrun} !== 4'b1110) begin
      errs++;
      $display("FAIL same_load got=%b want=1110",
               {cyc % 256 == 4, o_frame_req, o_underrun, o_overrun});
    end
    capture(sd, lr);
    want = MUTE ? 64'h0 : exp_sd(16'h2222, 16'h3333);
    vecs++;
    if (sd !== want) begin
      errs++;
      $display("FAIL same_under_frame got=%h want=%h", sd, want);
    end
    goto_load();
    vecs++;
    if ({o_frame_req, o_underrun} !== 2'b10) begin
      errs++;
      $display("FAIL same_next_load got=%b want=10",
               {o_frame_req, o_underrun});
    end
    capture(sd, lr);
    vecs++;
    if (sd !== exp_sd(16'h7FFF, 16'h1234)) begin
      errs++;
      $display("FAIL same_next_frame got=%h want=%h", sd,
               exp_sd(16'h7FFF, 16'h1234));
    end
  endtask

  task automatic test_hold();
    logic [63:0] sd, lr, want;
    want = MUTE ? 64'h0 : exp_sd(16'h7FFF, 16'h1234);
    for (int f = 0; f < 2; f++) begin
      goto_load();
      vecs++;
      if ({o_frame_req, o_underrun} !== 2'b11) begin
        errs++;
        $display("FAIL hold%0d_load got=%b want=11", f,
                 {o_frame_req, o_underrun});
      end
      capture(sd, lr);
      vecs++;
      if (sd !== want) begin
        errs++;
        $display("FAIL hold%0d_frame got=%h want=%h", f, sd, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    goto_load();
    repeat (40*4) step();
    vecs++;
    if (o_lrck !== 1'b1) begin
      errs++;
      $display("FAIL mid_lrck got=%b want=1", o_lrck);
    end
    #1;
    rst_n = 1'b0;
    #1;
    test_reset();
  endtask

  initial begin
    #12;
    test_reset();
    test_pattern();
    test_overrun();
    test_same_clk();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
